scmp_bus_arb: RTL and testbench

Shares the external 16-bit memory bus between the scmp core and one DMA master. It captures the core's multiplexed address-strobe phase (12-bit address plus high nibble and flags on D_o) and runs memory strobes with a programmable minimum length. It stalls the core through `cpu_hold` while the bus is busy or memory inserts wait states. Arbitration is round-robin between the two masters, on cycle boundaries only.

---
 rtl/scmp_bus_arb_if.sv | 19 +
 rtl/scmp_bus_arb.sv | 126 ++++++++++++
 tb/tb_scmp_bus_arb.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scmp_bus_arb_if.sv
// rtl/scmp_bus_arb_if.sv - external memory bus shared by the scmp core and the DMA master
interface scmp_bus_arb_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_rdata;
    logic        mem_wait;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata, mem_wait
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata, mem_wait
    );
endinterface

// File: rtl/scmp_bus_arb.sv
// rtl/scmp_bus_arb.sv - round-robin memory bus arbiter between the scmp core and a DMA master
module scmp_bus_arb #(
    parameter int STROBE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_ads_n,
    input  logic                  cpu_rd_n,
    input  logic                  cpu_wr_n,
    input  logic [11:0]           cpu_addr,
    input  logic [7:0]            cpu_d_o,
    output logic [7:0]            cpu_d_i,
    output logic                  cpu_hold,
    output logic [3:0]            cpu_flags,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [15:0]           dma_addr,
    input  logic [7:0]            dma_wdata,
    output logic                  dma_ack,
    output logic [7:0]            dma_rdata,
    scmp_bus_arb_if.master        mem
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CPU_ADDR = 3'd1;
    localparam logic [2:0] S_CPU_STB  = 3'd2;
    localparam logic [2:0] S_DMA_STB  = 3'd3;
    localparam logic [2:0] S_DMA_END  = 3'd4;
    localparam logic [3:0] CNT_LOAD   = 4'(STROBE_CYC - 1);

    logic [2:0] state;
    logic [3:0] cnt;
    logic       last_dma;
    logic       cpu_req;
    logic       dma_pend;
    logic       grant_dma;
    logic       grant_cpu;

    // The acked request is still high during the ack cycle; masking it stops a re-grant.
    assign cpu_req   = !cpu_ads_n;
    assign dma_pend  = dma_req && !dma_ack;
    assign grant_dma = (state == S_IDLE) && dma_pend && (!cpu_req || !last_dma);
    assign grant_cpu = (state == S_IDLE) && cpu_req && !grant_dma;

    assign cpu_hold = (cpu_req && (state == S_DMA_STB || state == S_DMA_END))
                    || (cpu_req && grant_dma)
                    || (state == S_CPU_STB && (cnt != 4'd0 || mem.mem_wait));

    assign cpu_d_i = (state == S_CPU_STB) ? mem.mem_rdata : 8'hFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            last_dma      <= 1'b1;
            mem.mem_addr  <= 16'h0000;
            mem.mem_wdata <= 8'h00;
            mem.mem_rd    <= 1'b0;
            mem.mem_wr    <= 1'b0;
            dma_ack       <= 1'b0;
            dma_rdata     <= 8'h00;
            cpu_flags     <= 4'h0;
        end else begin
            dma_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_dma) begin
                        mem.mem_addr  <= dma_addr;
                        mem.mem_wdata <= dma_wdata;
                        mem.mem_rd    <= !dma_we;
                        mem.mem_wr    <= dma_we;
                        cnt           <= CNT_LOAD;
                        last_dma      <= 1'b1;
                        state         <= S_DMA_STB;
                    end else if (grant_cpu) begin
                        mem.mem_addr <= {cpu_d_o[3:0], cpu_addr};
                        cpu_flags    <= cpu_d_o[7:4];
                        last_dma     <= 1'b0;
                        state        <= S_CPU_ADDR;
                    end
                end
                S_CPU_ADDR: begin
                    if (!cpu_rd_n) begin
                        mem.mem_rd <= 1'b1;
                        cnt        <= CNT_LOAD;
                        state      <= S_CPU_STB;
                    end else if (!cpu_wr_n) begin
                        mem.mem_wr    <= 1'b1;
                        mem.mem_wdata <= cpu_d_o;
                        cnt           <= CNT_LOAD;
                        state         <= S_CPU_STB;
                    end
                end
                S_CPU_STB: begin
                    // Wait states freeze the count so each one lengthens the strobe by a clock.
                    if (!mem.mem_wait && cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                    if (cpu_rd_n && cpu_wr_n) begin
                        mem.mem_rd <= 1'b0;
                        mem.mem_wr <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_DMA_STB: begin
                    if (!mem.mem_wait) begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            if (mem.mem_rd) begin
                                dma_rdata <= mem.mem_rdata;
                            end
                            mem.mem_rd <= 1'b0;
                            mem.mem_wr <= 1'b0;
                            state      <= S_DMA_END;
                        end
                    end
                end
                S_DMA_END: begin
                    dma_ack <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scmp_bus_arb.sv
// tb/tb_scmp_bus_arb.sv - randomized scoreboard bench for scmp_bus_arb
module tb_scmp_bus_arb;
    localparam int SC = 2;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        logic [3:0]  flags;
        logic        is_dma;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ads_n, cpu_rd_n, cpu_wr_n;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_d_o;
    logic [7:0]  cpu_d_i;
    logic        cpu_hold;
    logic [3:0]  cpu_flags;
    logic        dma_req, dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;

    logic        d1_req, d1_we;
    logic [15:0] d1_addr;
    logic [7:0]  d1_wdata;
    logic        d1_ack;
    logic [7:0]  d1_rdata;
    logic [7:0]  c1_d_i;
    logic        c1_hold;
    logic [3:0]  c1_flags;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_ack = 0;
    int   force_wait = -1;
    int   cur_wait = 0;
    logic m_last_dma = 1'b1;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    scmp_bus_arb_if bus ();
    scmp_bus_arb_if bus1 ();

    scmp_bus_arb #(.STROBE_CYC(SC)) dut (
        .clk(clk), .rst(rst),
        .cpu_ads_n(cpu_ads_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_d_o(cpu_d_o), .cpu_d_i(cpu_d_i),
        .cpu_hold(cpu_hold), .cpu_flags(cpu_flags),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem(bus.master)
    );

    scmp_bus_arb #(.STROBE_CYC(1)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_ads_n(1'b1), .cpu_rd_n(1'b1), .cpu_wr_n(1'b1),
        .cpu_addr(12'h000), .cpu_d_o(8'h00), .cpu_d_i(c1_d_i),
        .cpu_hold(c1_hold), .cpu_flags(c1_flags),
        .dma_req(d1_req), .dma_we(d1_we), .dma_addr(d1_addr), .dma_wdata(d1_wdata),
        .dma_ack(d1_ack), .dma_rdata(d1_rdata),
        .mem(bus1.master)
    );

    function automatic logic [7:0] memfn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h6A;
    endfunction

    assign bus.mem_rdata  = memfn(bus.mem_addr);
    assign bus1.mem_rdata = memfn(bus1.mem_addr);
    assign bus1.mem_wait  = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push_exp(input logic [15:0] a, input logic wr, input logic [7:0] wd,
                                     input logic [3:0] fl, input logic is_dma);
        exp_t e;
        e.addr = a; e.wr = wr; e.wdata = wd; e.flags = fl; e.is_dma = is_dma;
        exp_q.push_back(e);
        m_last_dma = is_dma;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: wait states occupy the first cur_wait cycles of each strobe.
    initial begin
        int   budget;
        logic prev_stb, stb;
        bus.mem_wait = 1'b0;
        budget = 0;
        prev_stb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.mem_wait = 1'b0;
                prev_stb = 1'b0;
                budget = 0;
            end else begin
                stb = bus.mem_rd | bus.mem_wr;
                if (stb && !prev_stb) begin
                    budget = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                    cur_wait = budget;
                end
                if (stb && budget > 0) begin
                    bus.mem_wait = 1'b1;
                    budget--;
                end else begin
                    bus.mem_wait = 1'b0;
                end
                prev_stb = stb;
            end
        end
    end

    // Monitor: pops one expectation per strobe and checks the DMA completion.
    initial begin
        exp_t cur;
        logic in_stb, cur_ok, stb, ack_pend, ack_rd;
        int   len, hold_cnt, start_cyc, ack_start, ack_len;
        logic [7:0] ack_data;
        in_stb = 0; ack_pend = 0; cur_ok = 0;
        len = 0; hold_cnt = 0; start_cyc = 0; ack_start = 0; ack_len = 0; ack_rd = 0; ack_data = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_rd && bus.mem_wr) chk("strobe_exclusive", 32'(bus.mem_wr), 32'd0);
            if (rst) begin
                if (in_stb && cur_ok) exp_q.push_front(cur);
                in_stb = 0;
                ack_pend = 0;
            end else begin
                stb = bus.mem_rd | bus.mem_wr;
                if (stb && !in_stb) begin
                    in_stb = 1; len = 0; hold_cnt = 0; start_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        cur_ok = 0;
                        chk("unexpected_strobe", 32'(stb), 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        cur_ok = 1;
                        chk("mem_addr", 32'(bus.mem_addr), 32'(cur.addr));
                        chk("strobe_type", 32'(bus.mem_wr), 32'(cur.wr));
                        if (cur.wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(cur.wdata));
                        if (!cur.is_dma) chk("cpu_flags", 32'(cpu_flags), 32'(cur.flags));
                    end
                end
                if (stb) begin
                    len++;
                    if (cpu_hold) hold_cnt++;
                end
                if (!stb && in_stb) begin
                    in_stb = 0;
                    chk("strobe_len", 32'(len), 32'(SC + cur_wait));
                    if (cur_ok && !cur.is_dma) chk("cpu_hold_cycles", 32'(hold_cnt), 32'(len - 1));
                    if (cur_ok && cur.is_dma) begin
                        ack_pend = 1; ack_start = start_cyc; ack_len = len;
                        ack_rd = !cur.wr; ack_data = memfn(cur.addr);
                    end
                end
                if (dma_ack) begin
                    n_ack++;
                    chk("ack_expected", 32'(ack_pend), 32'd1);
                    if (ack_pend) begin
                        chk("dma_ack_latency", 32'(cyc - ack_start), 32'(ack_len + 1));
                        if (ack_rd) chk("dma_rdata", 32'(dma_rdata), 32'(ack_data));
                    end
                    ack_pend = 0;
                end
            end
        end
    end

    task automatic cpu_access(input logic [15:0] a, input logic [3:0] fl, input logic wr,
                              input logic [7:0] wd, input logic chk_hold);
        int n;
        @(negedge clk);
        cpu_ads_n = 1'b0;
        cpu_addr  = a[11:0];
        cpu_d_o   = {fl, a[15:12]};
        #1;
        if (chk_hold) chk("hold_during_dma", 32'(cpu_hold), 32'd1);
        n = 0;
        while (cpu_hold && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (cpu_hold) chk("cpu_grant_timeout", 32'(cpu_hold), 32'd0);
        @(posedge clk);
        #1;
        cpu_ads_n = 1'b1;
        if (wr) begin
            cpu_wr_n = 1'b0;
            cpu_d_o  = wd;
        end else begin
            cpu_rd_n = 1'b0;
        end
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (cpu_hold && n < 300);
        if (!wr) chk("cpu_d_i", 32'(cpu_d_i), 32'(memfn(a)));
        cpu_rd_n = 1'b1;
        cpu_wr_n = 1'b1;
        cpu_d_o  = 8'($urandom);
    endtask

    task automatic dma_access(input logic [15:0] a, input logic we, input logic [7:0] wd);
        int n;
        @(negedge clk);
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dma_ack && n < 300);
        chk("dma_ack_seen", 32'(dma_ack), 32'd1);
        dma_req  = 1'b0;
        dma_addr = 16'($urandom);
    endtask

    task automatic tie(input logic [15:0] ca, input logic [3:0] fl, input logic cw, input logic [7:0] cd,
                       input logic [15:0] da, input logic dw, input logic [7:0] dd);
        if (m_last_dma) begin
            push_exp(ca, cw, cd, fl, 1'b0);
            push_exp(da, dw, dd, 4'h0, 1'b1);
        end else begin
            push_exp(da, dw, dd, 4'h0, 1'b1);
            push_exp(ca, cw, cd, fl, 1'b0);
        end
        fork
            cpu_access(ca, fl, cw, cd, 1'b0);
            dma_access(da, dw, dd);
        join
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        int n, g, ack0;
        logic [15:0] a, a2;
        logic [7:0]  d, d2;
        logic [3:0]  fl;
        rst = 1'b1;
        cpu_ads_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_addr = 12'h000; cpu_d_o = 8'h00;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00;
        d1_req = 1'b0; d1_we = 1'b0; d1_addr = 16'h0000; d1_wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_dma_rdata", 32'(dma_rdata), 32'd0);
        chk("rst_cpu_flags", 32'(cpu_flags), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_cpu_d_i", 32'(cpu_d_i), 32'hFF);

        // Simultaneous requests straight out of reset: CPU, DMA, then CPU again.
        force_wait = 0;
        tie(16'h1234, 4'h5, 1'b0, 8'h00, 16'h8001, 1'b1, 8'h42);
        tie(16'h2468, 4'h3, 1'b1, 8'h99, 16'h4002, 1'b0, 8'h00);

        // STROBE_CYC=1 instance: read and write latencies.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            d1_req = 1'b1; d1_we = (k == 1); d1_addr = (k == 0) ? 16'h0054 : 16'hA5A5; d1_wdata = 8'h77;
            n = 0;
            while (!(bus1.mem_rd | bus1.mem_wr) && n < 50) begin @(negedge clk); n++; end
            chk("dut1_strobe_type", 32'(bus1.mem_wr), 32'(k == 1));
            g = cyc;
            n = 0;
            while (!d1_ack && n < 50) begin @(negedge clk); n++; end
            chk("dut1_ack_latency", 32'(cyc - g), 32'd2);
            chk("dut1_rdata", 32'(d1_rdata), 32'h3E);
            d1_req = 1'b0;
        end

        force_wait = 0;
        push_exp(16'h7345, 1'b0, 8'h00, 4'hA, 1'b0);
        cpu_access(16'h7345, 4'hA, 1'b0, 8'h00, 1'b0);
        chk("cpu_read_data_5c", 32'(memfn(bus.mem_addr)), 32'h5C);

        force_wait = 3;
        push_exp(16'hFFFF, 1'b1, 8'h81, 4'h0, 1'b1);
        dma_access(16'hFFFF, 1'b1, 8'h81);

        // ADS arriving while a DMA strobe is in progress.
        force_wait = 2;
        push_exp(16'h0C0D, 1'b0, 8'h00, 4'h0, 1'b1);
        fork
            dma_access(16'h0C0D, 1'b0, 8'h00);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!(bus.mem_rd | bus.mem_wr) && n < 50);
                push_exp(16'hB0B1, 1'b1, 8'h3C, 4'h6, 1'b0);
                cpu_access(16'hB0B1, 4'h6, 1'b1, 8'h3C, 1'b1);
            end
        join

        // Reset in the middle of a DMA strobe; the request stays up and re-runs.
        force_wait = 3;
        push_exp(16'h5A5A, 1'b1, 8'hC3, 4'h0, 1'b1);
        @(negedge clk);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h5A5A; dma_wdata = 8'hC3;
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.mem_rd | bus.mem_wr) && n < 50);
        ack0 = n_ack;
        @(negedge clk);
        rst = 1'b1;
        m_last_dma = 1'b1;
        @(negedge clk);
        chk("rst_mid_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
        chk("rst_mid_no_ack", 32'(dma_ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!dma_ack && n < 100);
        chk("rst_rerun_ack", 32'(dma_ack), 32'd1);
        dma_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_rerun_ack_count", 32'(n_ack - ack0), 32'd1);

        force_wait = -1;
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = int'($urandom_range(0, 4));
            a = 16'($urandom); d = 8'($urandom); fl = 4'($urandom);
            a2 = 16'($urandom); d2 = 8'($urandom);
            case (kind)
                0, 1: begin
                    push_exp(a, kind[0], d, fl, 1'b0);
                    cpu_access(a, fl, kind[0], d, 1'b0);
                end
                2, 3: begin
                    push_exp(a, kind[0], d, 4'h0, 1'b1);
                    dma_access(a, kind[0], d);
                end
                default: tie(a, fl, d[0], d, a2, d2[0], d2);
            endcase
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
